// File: rtl/serial_fa_ctrl.sv
// serial_fa_ctrl: bit-serial adder/subtractor sequencer.
// One 1-bit full adder is reused over WIDTH cycles, LSB first, with a
// registered carry between bits. Subtraction is A + ~B + ~borrow_in, so
// the same adder path serves both operations.
//
// Handshake: start is sampled only in IDLE or DONE. busy is high for the
// WIDTH RUN cycles, and done pulses for one cycle after the last bit.
// sum/cout/ovf hold the previous result until the next completion edge.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    // Plain combinational full adder.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end
endmodule

module serial_fa_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Control strobes decoded from the state.
    logic accept;
    logic running;
    logic last;

    // Single shared full-adder cell.
    logic fa_s;
    logic fa_co;

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start accepted from IDLE or DONE; RUN ignores it.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = (cnt == LAST_BIT) ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output and strobe decode from the current state.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        running = 1'b0;
        last    = 1'b0;
        case (state)
            S_IDLE: begin
                accept = start;
            end
            S_RUN: begin
                busy    = 1'b1;
                running = 1'b1;
                last    = (cnt == LAST_BIT);
            end
            S_DONE: begin
                done   = 1'b1;
                accept = start;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture on accept, one bit per RUN edge, and the
    // result registers updated only on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            // Subtract as A + ~B + ~borrow_in.
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (running) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            if (last) begin
                // carry here is the carry into the MSB stage.
                sum  <= {fa_s, res_sr[WIDTH-1:1]};
                cout <= fa_co;
                ovf  <= carry ^ fa_co;
            end
        end
    end
endmodule

// File: doc/serial_fa_ctrl.md
Name: serial_fa_ctrl

Overview:
- Bit-serial adder/subtractor sequencer. Reuses one 1-bit full adder (S = A^B^Cin; Cout = A·B + Cin·(A^B)) over WIDTH clock cycles, LSB first, with a registered carry between bits.
- Sits beside the combinational ripple adders in the adder/multiplier library as the area-minimal alternative.
- Also serves as the add step of the later shift-add multiplier controller.
- Start/busy/done handshake to the requester.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = add (A+B+cin); 1 = subtract (A−B−cin, cin is borrow-in); latched with start.
- a  in  WIDTH  operand A; latched on start acceptance.
- b  in  WIDTH  operand B; latched on start acceptance.
- cin  in  1  carry-in (add) / borrow-in (sub); latched on start acceptance.
- busy  out  1  high while a serial operation is in progress.
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  result; held stable from done until the next completion.
- cout  out  1  final carry; for sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift regs, carry and bit counter cleared. Reset has priority over everything, including mid-RUN (the operation is aborted and no done pulse is produced).
- States: IDLE, RUN, DONE.
- IDLE, start=0: stay in IDLE.
- IDLE, start=1 (acceptance edge): latch the operands.
  - a_sr <= a
  - b_sr <= b ^ {WIDTH{sub}}
  - carry <= cin ^ sub
  - cnt <= 0
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - FA inputs: a_sr[0], b_sr[0], carry.
  - The FA sum bit shifts into res_sr at the MSB end; a_sr and b_sr shift right.
  - carry <= FA cout.
  - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH−1, the edge also does the following:
    - sum <= final res_sr, including the current bit.
    - cout <= final FA cout.
    - ovf <= carry into the MSB XOR final FA cout (the MSB-stage carry-in is the carry register value on that edge).
    - State goes to DONE.
- RUN ignores start and any change on a, b, sub and cin.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle gap).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0 → RUN edges E1..EWIDTH → done high in the cycle after EWIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- sum, cout and ovf change only on the completion edge or on reset; the previous result stays visible during RUN.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Counter width is ceil(log2(WIDTH)). The counter does not need to wrap beyond WIDTH−1 because the state leaves RUN.
- The full adder is instantiated as a single 1-bit cell, not inferred as a WIDTH-bit "+".

Test Plan (WIDTH=8):
1. Add with overflow: a=0x5A, b=0x33, sub=0, cin=0, start pulse → done exactly 9 cycles after the start edge. Result: sum=0x8D, cout=0, ovf=1. busy high for 8 cycles.
2. Carry-in and wrap:
   - 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0.
   - Then 0x7F+0x00, cin=1 → sum=0x80, cout=0, ovf=1.
3. Subtract:
   - a=0x10, b=0x20, sub=1, cin=0 → sum=0xF0, cout=0 (borrow), ovf=0.
   - a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
4. Busy protection: start 0x01+0x01; on RUN cycle 3, pulse start with a=0xFF, b=0xFF and toggle sub. Response: sum=0x02, only one done pulse, and no second operation begins.
5. Reset mid-operation: assert rst during RUN cycle 4 → next cycle busy=0, done=0, sum=0x00. No done pulse follows. A subsequent 0x0F+0x01 gives sum=0x10.
6. Back-to-back: hold start=1 continuously with 0x03+0x04, then 0x10+0x20.
   - done pulses 9 cycles apart.
   - Results 0x07 then 0x30.
   - sum is stable between the two pulses.
